// File: rtl/rvvi_csr_pkg.sv
// CSR address constants and the shared rvvi index table for the CSR-write collector.
package rvvi_csr_pkg;

    localparam int CSR_COUNT_BASE = 36;
    localparam int CSR_COUNT_FULL = 54;

    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MSTATUSH      = 12'h310;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCOUNTEREN    = 12'h306;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MEDELEG       = 12'h302;
    localparam logic [11:0] CSR_MIDELEG       = 12'h303;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MISA          = 12'h301;
    localparam logic [11:0] CSR_MENVCFG       = 12'h30A;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
    localparam logic [11:0] CSR_MARCHID       = 12'hF12;
    localparam logic [11:0] CSR_MIMPID        = 12'hF13;
    localparam logic [11:0] CSR_MCONFIGPTR    = 12'hF15;
    localparam logic [11:0] CSR_MTINST        = 12'h34A;
    localparam logic [11:0] CSR_SSTATUS       = 12'h100;
    localparam logic [11:0] CSR_SIE           = 12'h104;
    localparam logic [11:0] CSR_STVEC         = 12'h105;
    localparam logic [11:0] CSR_SEPC          = 12'h141;
    localparam logic [11:0] CSR_SCOUNTEREN    = 12'h106;
    localparam logic [11:0] CSR_SENVCFG       = 12'h10A;
    localparam logic [11:0] CSR_SATP          = 12'h180;
    localparam logic [11:0] CSR_SSCRATCH      = 12'h140;
    localparam logic [11:0] CSR_STVAL         = 12'h143;
    localparam logic [11:0] CSR_SCAUSE        = 12'h142;
    localparam logic [11:0] CSR_SIP           = 12'h144;
    localparam logic [11:0] CSR_STIMECMP      = 12'h14D;
    localparam logic [11:0] CSR_FFLAGS        = 12'h001;
    localparam logic [11:0] CSR_FRM           = 12'h002;
    localparam logic [11:0] CSR_FCSR          = 12'h003;
    localparam logic [11:0] CSR_PMPADDR0      = 12'h3B0;
    localparam logic [11:0] CSR_PMPCFG0       = 12'h3A0;
    localparam logic [11:0] CSR_PMPCFG2       = 12'h3A2;

    // Entry i is the CSR address carried by rvvi index i; used in both directions.
    localparam logic [11:0] CSR_INDEX_ADDR [0:CSR_COUNT_FULL-1] = '{
        CSR_MSTATUS, CSR_MSTATUSH, CSR_MTVEC, CSR_MEPC, CSR_MCOUNTEREN,
        CSR_MCOUNTINHIBIT, CSR_MEDELEG, CSR_MIDELEG, CSR_MIP, CSR_MIE,
        CSR_MISA, CSR_MENVCFG, CSR_MHARTID, CSR_MSCRATCH, CSR_MCAUSE,
        CSR_MTVAL, CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MCONFIGPTR,
        CSR_MTINST, CSR_SSTATUS, CSR_SIE, CSR_STVEC, CSR_SEPC,
        CSR_SCOUNTEREN, CSR_SENVCFG, CSR_SATP, CSR_SSCRATCH, CSR_STVAL,
        CSR_SCAUSE, CSR_SIP, CSR_STIMECMP, CSR_FFLAGS, CSR_FRM,
        CSR_FCSR,
        CSR_PMPADDR0 + 12'h000, CSR_PMPADDR0 + 12'h001, CSR_PMPADDR0 + 12'h002,
        CSR_PMPADDR0 + 12'h003, CSR_PMPADDR0 + 12'h004, CSR_PMPADDR0 + 12'h005,
        CSR_PMPADDR0 + 12'h006, CSR_PMPADDR0 + 12'h007, CSR_PMPADDR0 + 12'h008,
        CSR_PMPADDR0 + 12'h009, CSR_PMPADDR0 + 12'h00A, CSR_PMPADDR0 + 12'h00B,
        CSR_PMPADDR0 + 12'h00C, CSR_PMPADDR0 + 12'h00D, CSR_PMPADDR0 + 12'h00E,
        CSR_PMPADDR0 + 12'h00F,
        CSR_PMPCFG0, CSR_PMPCFG2
    };

    typedef enum logic [0:0] {
        FRAME_EMPTY = 1'b0,
        FRAME_FULL  = 1'b1
    } frame_state_e;

    function automatic logic total_csrs_legal(input int n);
        return (n == CSR_COUNT_BASE) || (n == CSR_COUNT_FULL);
    endfunction

endpackage

// File: rtl/csr_addr_to_index.sv
// Combinational decode of a 12-bit CSR address into its rvvi one-hot index.
module csr_addr_to_index
    import rvvi_csr_pkg::*;
#(
    parameter int TOTAL_CSRS = 54
) (
    input  logic [11:0]           addr,
    output logic [TOTAL_CSRS-1:0] onehot,
    output logic                  hit
);

    // Compare the address against every table entry that exists in this index space.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < TOTAL_CSRS; i++) begin
            onehot[i] = (addr == CSR_INDEX_ADDR[i]);
        end
        hit = |onehot;
    end

endmodule

// File: rtl/rvvi_csr_collector.sv
// Collects per-instruction CSR write records and emits one rvvi frame per retired instruction.
module rvvi_csr_collector
    import rvvi_csr_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int TOTAL_CSRS = 54
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       InReady,
    input  logic                       CSRWriteValid,
    input  logic [11:0]                CSRWriteAddr,
    input  logic [XLEN-1:0]            CSRWriteData,
    input  logic                       InstrRetire,
    output logic                       FrameValid,
    input  logic                       FrameReady,
    output logic [TOTAL_CSRS-1:0]      CSRWen,
    output logic [TOTAL_CSRS*XLEN-1:0] CSRValues,
    output logic [15:0]                FrameSeq,
    output logic                       UnknownCSR,
    output logic [11:0]                UnknownAddr
);

    generate
        if (!total_csrs_legal(TOTAL_CSRS)) begin : g_bad_total_csrs
            $error("rvvi_csr_collector: TOTAL_CSRS must be 36 or 54");
        end
    endgenerate

    logic                                 in_ready_s;
    logic                                 addr_hit_s;
    logic [TOTAL_CSRS-1:0]                addr_onehot_s;
    logic                                 wr_hit_s;
    logic                                 wr_miss_s;
    logic                                 retire_s;
    logic [TOTAL_CSRS-1:0]                acc_wen_r;
    logic [TOTAL_CSRS-1:0][XLEN-1:0]      acc_val_r;
    logic [TOTAL_CSRS-1:0]                merged_wen_s;
    logic [TOTAL_CSRS-1:0][XLEN-1:0]      merged_val_s;
    logic [TOTAL_CSRS-1:0]                frame_wen_r;
    logic [TOTAL_CSRS-1:0][XLEN-1:0]      frame_val_r;
    logic [15:0]                          frame_seq_r;
    logic [15:0]                          retire_cnt_r;
    logic                                 unknown_r;
    logic [11:0]                          unknown_addr_r;
    frame_state_e                         state_r;
    frame_state_e                         state_next_s;
    logic                                 frame_valid_s;

    csr_addr_to_index #(
        .TOTAL_CSRS (TOTAL_CSRS)
    ) u_decode (
        .addr   (CSRWriteAddr),
        .onehot (addr_onehot_s),
        .hit    (addr_hit_s)
    );

    // Inputs are only consumed when the output slot is empty or being drained this cycle.
    always_comb begin
        in_ready_s = ~frame_valid_s | FrameReady;
        wr_hit_s   = in_ready_s & CSRWriteValid & addr_hit_s;
        wr_miss_s  = in_ready_s & CSRWriteValid & ~addr_hit_s;
        retire_s   = in_ready_s & InstrRetire;
    end

    // Accumulator view including this cycle's write, so a same-cycle retire sees it.
    always_comb begin
        merged_wen_s = acc_wen_r;
        merged_val_s = acc_val_r;
        for (int i = 0; i < TOTAL_CSRS; i++) begin
            if (wr_hit_s && addr_onehot_s[i]) begin
                merged_wen_s[i] = 1'b1;
                merged_val_s[i] = CSRWriteData;
            end else begin
                merged_wen_s[i] = acc_wen_r[i];
                merged_val_s[i] = acc_val_r[i];
            end
        end
    end

    // Per-instruction accumulator: cleared on retire, last write to an index wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_wen_r <= '0;
            acc_val_r <= '0;
        end else if (retire_s) begin
            acc_wen_r <= '0;
            acc_val_r <= '0;
        end else begin
            acc_wen_r <= merged_wen_s;
            acc_val_r <= merged_val_s;
        end
    end

    // Output slot state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= FRAME_EMPTY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Output slot next state: a retire always refills, a bare handshake drains.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            FRAME_EMPTY: begin
                if (retire_s) begin
                    state_next_s = FRAME_FULL;
                end else begin
                    state_next_s = FRAME_EMPTY;
                end
            end
            FRAME_FULL: begin
                if (FrameReady && !retire_s) begin
                    state_next_s = FRAME_EMPTY;
                end else begin
                    state_next_s = FRAME_FULL;
                end
            end
            default: begin
                state_next_s = FRAME_EMPTY;
            end
        endcase
    end

    // Output slot decode.
    always_comb begin
        frame_valid_s = 1'b0;
        case (state_r)
            FRAME_FULL:  frame_valid_s = 1'b1;
            FRAME_EMPTY: frame_valid_s = 1'b0;
            default:     frame_valid_s = 1'b0;
        endcase
    end

    // Frame payload loads only on retire, so it holds while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_wen_r <= '0;
            frame_val_r <= '0;
            frame_seq_r <= 16'h0000;
        end else if (retire_s) begin
            frame_wen_r <= merged_wen_s;
            frame_val_r <= merged_val_s;
            frame_seq_r <= retire_cnt_r;
        end else begin
            frame_wen_r <= frame_wen_r;
            frame_val_r <= frame_val_r;
            frame_seq_r <= frame_seq_r;
        end
    end

    // Retire sequence counter, wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt_r <= 16'h0000;
        end else if (retire_s) begin
            retire_cnt_r <= retire_cnt_r + 16'h0001;
        end else begin
            retire_cnt_r <= retire_cnt_r;
        end
    end

    // Sticky unmapped-address flag; only the first offending address is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            unknown_r      <= 1'b0;
            unknown_addr_r <= 12'h000;
        end else if (wr_miss_s) begin
            unknown_r <= 1'b1;
            if (!unknown_r) begin
                unknown_addr_r <= CSRWriteAddr;
            end else begin
                unknown_addr_r <= unknown_addr_r;
            end
        end else begin
            unknown_r      <= unknown_r;
            unknown_addr_r <= unknown_addr_r;
        end
    end

    assign InReady     = in_ready_s;
    assign FrameValid  = frame_valid_s;
    assign CSRWen      = frame_wen_r;
    assign CSRValues   = frame_val_r;
    assign FrameSeq    = frame_seq_r;
    assign UnknownCSR  = unknown_r;
    assign UnknownAddr = unknown_addr_r;

endmodule

// File: tb/tb_rvvi_csr_collector.sv
// Scoreboard bench: a 54-index and a 36-index collector driven by the same random stream.
module tb_rvvi_csr_collector;

    typedef struct packed {
        logic [53:0]      wen;
        logic [54*64-1:0] vals;
        logic [15:0]      seq;
    } frame_t;

    logic clk = 1'b0;
    logic reset;
    logic CSRWriteValid;
    logic [11:0] CSRWriteAddr;
    logic [63:0] CSRWriteData;
    logic InstrRetire;
    logic FrameReady;

    logic a_in_ready, a_fv, a_unk;
    logic [53:0] a_wen;
    logic [54*64-1:0] a_vals;
    logic [15:0] a_seq;
    logic [11:0] a_uaddr;

    logic b_in_ready, b_fv, b_unk;
    logic [35:0] b_wen;
    logic [36*64-1:0] b_vals;
    logic [15:0] b_seq;
    logic [11:0] b_uaddr;

    int n_checks = 0;
    int n_fail = 0;

    // rvvi index map written out from the index definition, bit 0 upward
    logic [11:0] map_tbl [54] = '{
        12'h300, 12'h310, 12'h305, 12'h341, 12'h306, 12'h320, 12'h302, 12'h303, 12'h344,
        12'h304, 12'h301, 12'h30A, 12'hF14, 12'h340, 12'h342, 12'h343, 12'hF11, 12'hF12,
        12'hF13, 12'hF15, 12'h34A, 12'h100, 12'h104, 12'h105, 12'h141, 12'h106, 12'h10A,
        12'h180, 12'h140, 12'h143, 12'h142, 12'h144, 12'h14D, 12'h001, 12'h002, 12'h003,
        12'h3B0, 12'h3B1, 12'h3B2, 12'h3B3, 12'h3B4, 12'h3B5, 12'h3B6, 12'h3B7, 12'h3B8,
        12'h3B9, 12'h3BA, 12'h3BB, 12'h3BC, 12'h3BD, 12'h3BE, 12'h3BF, 12'h3A0, 12'h3A2
    };

    // reference model state, [0] = 54-index DUT, [1] = 36-index DUT
    logic [63:0] m_val [2][54];
    logic [53:0] m_wen [2];
    logic        m_unk [2];
    logic [11:0] m_uaddr [2];
    logic [15:0] m_seq;
    frame_t qa[$];
    frame_t qb[$];

    rvvi_csr_collector #(.XLEN(64), .TOTAL_CSRS(54)) dut_a (
        .clk(clk), .reset(reset), .InReady(a_in_ready),
        .CSRWriteValid(CSRWriteValid), .CSRWriteAddr(CSRWriteAddr), .CSRWriteData(CSRWriteData),
        .InstrRetire(InstrRetire), .FrameValid(a_fv), .FrameReady(FrameReady),
        .CSRWen(a_wen), .CSRValues(a_vals), .FrameSeq(a_seq),
        .UnknownCSR(a_unk), .UnknownAddr(a_uaddr)
    );

    rvvi_csr_collector #(.XLEN(64), .TOTAL_CSRS(36)) dut_b (
        .clk(clk), .reset(reset), .InReady(b_in_ready),
        .CSRWriteValid(CSRWriteValid), .CSRWriteAddr(CSRWriteAddr), .CSRWriteData(CSRWriteData),
        .InstrRetire(InstrRetire), .FrameValid(b_fv), .FrameReady(FrameReady),
        .CSRWen(b_wen), .CSRValues(b_vals), .FrameSeq(b_seq),
        .UnknownCSR(b_unk), .UnknownAddr(b_uaddr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int idx_for(input logic [11:0] a, input int total);
        for (int i = 0; i < total; i++) begin
            if (map_tbl[i] == a) return i;
        end
        return -1;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            m_wen[d] = '0;
            m_unk[d] = 1'b0;
            m_uaddr[d] = 12'h000;
            for (int i = 0; i < 54; i++) m_val[d][i] = 64'h0;
        end
        m_seq = 16'h0000;
        qa.delete();
        qb.delete();
    endtask

    task automatic model_accept(input logic wv, input logic [11:0] a, input logic [63:0] dat,
                                input logic ret);
        frame_t f;
        int idx;
        for (int d = 0; d < 2; d++) begin
            idx = wv ? idx_for(a, (d == 0) ? 54 : 36) : -1;
            if (wv && idx < 0) begin
                if (!m_unk[d]) m_uaddr[d] = a;
                m_unk[d] = 1'b1;
            end
            if (idx >= 0) begin
                m_wen[d][idx] = 1'b1;
                m_val[d][idx] = dat;
            end
            if (ret) begin
                f.wen = m_wen[d];
                f.seq = m_seq;
                for (int i = 0; i < 54; i++) f.vals[i*64 +: 64] = m_val[d][i];
                if (d == 0) qa.push_back(f); else qb.push_back(f);
                m_wen[d] = '0;
                for (int i = 0; i < 54; i++) m_val[d][i] = 64'h0;
            end
        end
        if (ret) m_seq = m_seq + 16'd1;
    endtask

    // one clock of stimulus; the model learns of an accepted record after the edge
    task automatic step(input logic wv, input logic [11:0] a, input logic [63:0] dat,
                        input logic ret, input logic rdy, output logic acc);
        @(negedge clk);
        CSRWriteValid = wv;
        CSRWriteAddr = a;
        CSRWriteData = dat;
        InstrRetire = ret;
        FrameReady = rdy;
        #1 acc = a_in_ready;
        @(posedge clk);
        #1;
        if (acc) model_accept(wv, a, dat, ret);
    endtask

    task automatic issue(input logic wv, input logic [11:0] a, input logic [63:0] dat,
                         input logic ret, input logic rdy);
        logic acc;
        acc = 1'b0;
        for (int t = 0; t < 16 && !acc; t++) step(wv, a, dat, ret, (t < 4) ? rdy : 1'b1, acc);
        chk("issue_accepted", {63'd0, acc}, 64'd1);
    endtask

    task automatic idle_drain();
        int t;
        @(negedge clk);
        CSRWriteValid = 1'b0;
        InstrRetire = 1'b0;
        FrameReady = 1'b1;
        t = 0;
        while ((qa.size() != 0 || qb.size() != 0) && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", 64'(qa.size() + qb.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        CSRWriteValid = 1'b0;
        InstrRetire = 1'b0;
        FrameReady = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_side(input int d, input logic iv, input logic fv, input logic [53:0] wen,
                              input logic [54*64-1:0] vals, input logic [15:0] seq,
                              input logic unk, input logic [11:0] uaddr);
        frame_t f;
        int qs;
        int bad;
        string p;
        p = (d == 0) ? "a54" : "b36";
        qs = (d == 0) ? qa.size() : qb.size();
        chk({p, ".frame_valid"}, {63'd0, fv}, {63'd0, qs != 0});
        chk({p, ".in_ready"}, {63'd0, iv}, {63'd0, (qs == 0) || FrameReady});
        chk({p, ".unknown_csr"}, {63'd0, unk}, {63'd0, m_unk[d]});
        chk({p, ".unknown_addr"}, {52'd0, uaddr}, {52'd0, m_uaddr[d]});
        if (fv && FrameReady && qs != 0) begin
            f = (d == 0) ? qa.pop_front() : qb.pop_front();
            chk({p, ".csr_wen"}, {10'd0, wen}, {10'd0, f.wen});
            chk({p, ".frame_seq"}, {48'd0, seq}, {48'd0, f.seq});
            bad = -1;
            for (int i = 53; i >= 0; i--) begin
                if (vals[i*64 +: 64] !== f.vals[i*64 +: 64]) bad = i;
            end
            n_checks++;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL %s.csr_values slice %0d: got %h expected %h", p, bad,
                         vals[bad*64 +: 64], f.vals[bad*64 +: 64]);
            end
        end
    endtask

    // monitor: inputs settle at the falling edge, compare shortly after
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            check_side(0, a_in_ready, a_fv, a_wen, a_vals, a_seq, a_unk, a_uaddr);
            check_side(1, b_in_ready, b_fv, {18'd0, b_wen}, {(18*64)'(0), b_vals}, b_seq,
                       b_unk, b_uaddr);
        end
    end

    initial begin
        logic acc;
        logic [15:0] first_seq;
        logic [11:0] ra;
        int r;
        reset = 1'b1;
        CSRWriteValid = 1'b0;
        CSRWriteAddr = 12'h000;
        CSRWriteData = 64'h0;
        InstrRetire = 1'b0;
        FrameReady = 1'b0;
        model_clear();
        do_reset();
        #3;
        chk("rst_frame_valid", {63'd0, a_fv}, 64'd0);
        chk("rst_csr_wen", {10'd0, a_wen}, 64'd0);
        chk("rst_csr_values", {63'd0, |a_vals}, 64'd0);
        chk("rst_frame_seq", {48'd0, a_seq}, 64'd0);
        chk("rst_unknown", {63'd0, a_unk}, 64'd0);

        // single write then retire; frame visible the cycle after
        issue(1'b1, 12'h300, 64'h1800, 1'b0, 1'b1);
        issue(1'b0, 12'h000, 64'h0, 1'b1, 1'b1);
        chk("t1_frame_valid", {63'd0, a_fv}, 64'd1);
        chk("t1_csr_wen", {10'd0, a_wen}, 64'h1);
        chk("t1_value0", a_vals[63:0], 64'h1800);
        chk("t1_seq", {48'd0, a_seq}, 64'd0);
        idle_drain();

        // repeated address keeps last value; write merged into retire cycle
        issue(1'b1, 12'h341, 64'hA, 1'b0, 1'b1);
        issue(1'b1, 12'h341, 64'hB, 1'b0, 1'b1);
        issue(1'b1, 12'h342, 64'hC, 1'b1, 1'b1);
        chk("t2_csr_wen", {10'd0, a_wen}, 64'h4008);
        chk("t2_slice3", a_vals[3*64 +: 64], 64'hB);
        chk("t2_slice14", a_vals[14*64 +: 64], 64'hC);
        idle_drain();

        // stall with a pending retire, then handshake and retire together
        do_reset();
        step(1'b1, 12'h305, 64'h55, 1'b1, 1'b0, acc);
        chk("t3_first_accept", {63'd0, acc}, 64'd1);
        first_seq = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 12'h341, 64'h77, 1'b1, 1'b0, acc);
            chk("t3_stall_accept", {63'd0, acc}, 64'd0);
            chk("t3_stall_in_ready", {63'd0, a_in_ready}, 64'd0);
            chk("t3_hold_seq", {48'd0, a_seq}, {48'd0, first_seq});
            chk("t3_hold_wen", {10'd0, a_wen}, 64'h4);
            chk("t3_hold_val", a_vals[2*64 +: 64], 64'h55);
        end
        step(1'b1, 12'h341, 64'h77, 1'b1, 1'b1, acc);
        chk("t3_b2b_accept", {63'd0, acc}, 64'd1);
        chk("t3_b2b_valid", {63'd0, a_fv}, 64'd1);
        chk("t3_b2b_seq", {48'd0, a_seq}, {48'd0, first_seq + 16'd1});
        idle_drain();

        // unmapped address then a PMP address, in both index spaces
        do_reset();
        issue(1'b1, 12'h7C0, 64'h1, 1'b0, 1'b1);
        issue(1'b1, 12'h3B0, 64'h2, 1'b0, 1'b1);
        issue(1'b0, 12'h000, 64'h0, 1'b1, 1'b1);
        chk("t4_a_unknown", {63'd0, a_unk}, 64'd1);
        chk("t4_a_uaddr", {52'd0, a_uaddr}, 64'h7C0);
        chk("t4_a_wen36", {63'd0, a_wen[36]}, 64'd1);
        chk("t4_b_uaddr", {52'd0, b_uaddr}, 64'h7C0);
        chk("t4_b_wen", {28'd0, b_wen}, 64'd0);
        idle_drain();

        // partial instruction is discarded by reset
        do_reset();
        issue(1'b1, 12'hF14, 64'h9, 1'b0, 1'b1);
        do_reset();
        issue(1'b0, 12'h000, 64'h0, 1'b1, 1'b1);
        chk("t5_csr_wen", {10'd0, a_wen}, 64'd0);
        chk("t5_seq", {48'd0, a_seq}, 64'd0);
        chk("t5_unknown", {63'd0, a_unk}, 64'd0);
        idle_drain();

        // randomized traffic
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 9);
            if (r < 7) ra = map_tbl[$urandom_range(0, 53)];
            else if (r == 7) ra = 12'h000;
            else if (r == 8) ra = 12'($urandom);
            else ra = 12'h341;
            issue(1'($urandom_range(0, 3) != 0), ra, {$urandom, $urandom},
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) < 7));
        end
        idle_drain();

        // 65537 empty instructions: sequence number wraps back to zero
        do_reset();
        for (int n = 0; n < 65537; n++) issue(1'b0, 12'h000, 64'h0, 1'b1, 1'b1);
        chk("t6_wrap_seq_a", {48'd0, a_seq}, 64'd0);
        chk("t6_wrap_seq_b", {48'd0, b_seq}, 64'd0);
        chk("t6_wrap_wen", {10'd0, a_wen}, 64'd0);
        idle_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
